comp4_bist: RTL and testbench

COMP4_BIST -- requirements
Module: comp4_bist

---
 rtl/comp4_bist_if.sv | 35 +++
 rtl/comp4_bist.sv | 119 +++++++++++
 tb/tb_comp4_bist.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/comp4_bist_if.sv
// ============================================================================
// comp4_bist_if : stimulus/response bundle between comp4_bist and its environment
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface comp4_bist_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       lt;
  logic       eq;
  logic       gt;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_cnt;
  logic [3:0] fail_a;
  logic [3:0] fail_b;
  logic [2:0] fail_flags;

  // BIST engine side
  modport master (
    input  start, lt, eq, gt,
    output a, b, busy, done, pass, err_cnt, fail_a, fail_b, fail_flags
  );

  // Environment side: controller plus comparator under test
  modport slave (
    output start, lt, eq, gt,
    input  a, b, busy, done, pass, err_cnt, fail_a, fail_b, fail_flags
  );
endinterface

`default_nettype wire

// File: rtl/comp4_bist.sv
// ============================================================================
// comp4_bist : exhaustive 256-pair self-test engine for a 4-bit comparator.
//              Optional macro COMP4_BIST_STOP_ON_FAIL_EN ends a sweep at first mismatch.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module comp4_bist (
  input  wire logic     clk,
  input  wire logic     rst_n,
  comp4_bist_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] exp_flags;
  logic [2:0] got_flags;
  logic       mismatch;
  logic       last_pair;
  logic [7:0] pair_next;
  logic [8:0] err_next;

  // Flag vectors are ordered {lt, eq, gt}
  always_comb begin
    exp_flags = {(bus.a < bus.b), (bus.a == bus.b), (bus.a > bus.b)};
    got_flags = {bus.lt, bus.eq, bus.gt};
    mismatch  = (got_flags != exp_flags);
    last_pair = (bus.a == 4'hF) && (bus.b == 4'hF);
    pair_next = {bus.a, bus.b} + 8'd1;
    err_next  = mismatch ? (bus.err_cnt + 9'd1) : bus.err_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.a          <= 4'd0;
      bus.b          <= 4'd0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.err_cnt    <= 9'd0;
      bus.fail_a     <= 4'd0;
      bus.fail_b     <= 4'd0;
      bus.fail_flags <= 3'd0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.a          <= 4'd0;
            bus.b          <= 4'd0;
            bus.busy       <= 1'b1;
            bus.pass       <= 1'b0;
            bus.err_cnt    <= 9'd0;
            bus.fail_a     <= 4'd0;
            bus.fail_b     <= 4'd0;
            bus.fail_flags <= 3'd0;
            state          <= DRIVE;
          end
        end

        // Operands were updated on the previous edge; give the comparator a cycle to settle
        DRIVE: begin
          state <= CHECK;
        end

        CHECK: begin
          if (mismatch) begin
            bus.err_cnt <= err_next;
            if (bus.err_cnt == 9'd0) begin
              bus.fail_a     <= bus.a;
              bus.fail_b     <= bus.b;
              bus.fail_flags <= got_flags;
            end
          end
`ifdef COMP4_BIST_STOP_ON_FAIL_EN
          if (mismatch || last_pair) begin
            bus.done <= 1'b1;
            bus.pass <= (err_next == 9'd0);
            state    <= FIN;
          end else begin
            {bus.a, bus.b} <= pair_next;
            state          <= DRIVE;
          end
`else
          if (last_pair) begin
            bus.done <= 1'b1;
            bus.pass <= (err_next == 9'd0);
            state    <= FIN;
          end else begin
            {bus.a, bus.b} <= pair_next;
            state          <= DRIVE;
          end
`endif
        end

        // done was raised on entry, so it is high for exactly this cycle
        FIN: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_comp4_bist.sv
// ============================================================================
// tb_comp4_bist : directed bench for comp4_bist with a fault-injectable comparator model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_comp4_bist;

  logic clk;
  logic rst_n;
  int   fault_mode;   // 0 good, 1 eq stuck-at-0, 2 lt/gt swapped
  int   vec;
  int   miss;
  logic [3:0] mid_a;
  logic [3:0] mid_b;
  logic       mid_busy;

`ifdef COMP4_BIST_STOP_ON_FAIL_EN
  localparam int EQ_LAT   = 3;
  localparam int EQ_ERR   = 1;
  localparam int SW_LAT   = 5;
  localparam int SW_ERR   = 1;
`else
  localparam int EQ_LAT   = 513;
  localparam int EQ_ERR   = 16;
  localparam int SW_LAT   = 513;
  localparam int SW_ERR   = 240;
`endif

  comp4_bist_if bus ();

  comp4_bist dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.lt = (bus.a < bus.b);
    bus.eq = (bus.a == bus.b);
    bus.gt = (bus.a > bus.b);
    if (fault_mode == 1) begin
      bus.eq = 1'b0;
    end else if (fault_mode == 2) begin
      bus.lt = (bus.a > bus.b);
      bus.gt = (bus.a < bus.b);
    end
  end

  // Pulses start for one cycle, then counts cycles until done (-1 on timeout)
  task automatic pulse_and_wait(output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 1200; c++) begin
      @(negedge clk);
      if (c == 111) begin
        mid_a    = bus.a;
        mid_b    = bus.b;
        mid_busy = bus.busy;
      end
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (bus.busy !== 1'b0)       begin miss++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vec++; if (bus.done !== 1'b0)       begin miss++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    vec++; if (bus.pass !== 1'b0)       begin miss++; $display("FAIL reset_pass got=%b exp=0", bus.pass); end
    vec++; if (bus.err_cnt !== 9'd0)    begin miss++; $display("FAIL reset_err got=%0d exp=0", bus.err_cnt); end
    vec++; if ({bus.a, bus.b} !== 8'd0) begin miss++; $display("FAIL reset_ab got=%h exp=00", {bus.a, bus.b}); end
    vec++; if ({bus.fail_a, bus.fail_b, bus.fail_flags} !== 11'd0)
      begin miss++; $display("FAIL reset_fail got=%h exp=0", {bus.fail_a, bus.fail_b, bus.fail_flags}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_good_sweep();
    int lat;
    fault_mode = 0;
    pulse_and_wait(lat);
    vec++; if (lat != 513)          begin miss++; $display("FAIL good_latency got=%0d exp=513", lat); end
    vec++; if (mid_busy !== 1'b1)   begin miss++; $display("FAIL good_mid_busy got=%b exp=1", mid_busy); end
    vec++; if ({mid_a, mid_b} !== 8'h37) begin miss++; $display("FAIL good_mid_ab got=%h exp=37", {mid_a, mid_b}); end
    vec++; if (bus.pass !== 1'b1)   begin miss++; $display("FAIL good_pass got=%b exp=1", bus.pass); end
    vec++; if (bus.err_cnt !== 9'd0) begin miss++; $display("FAIL good_err got=%0d exp=0", bus.err_cnt); end
    @(negedge clk);
    vec++; if (bus.busy !== 1'b0)   begin miss++; $display("FAIL good_busy_after got=%b exp=0", bus.busy); end
    vec++; if (bus.done !== 1'b0)   begin miss++; $display("FAIL good_done_width got=%b exp=0", bus.done); end
  endtask

  task automatic test_eq_stuck();
    int lat;
    fault_mode = 1;
    pulse_and_wait(lat);
    vec++; if (lat != EQ_LAT)          begin miss++; $display("FAIL eq_latency got=%0d exp=%0d", lat, EQ_LAT); end
    vec++; if (bus.err_cnt !== EQ_ERR[8:0]) begin miss++; $display("FAIL eq_err got=%0d exp=%0d", bus.err_cnt, EQ_ERR); end
    vec++; if (bus.fail_a !== 4'd0)    begin miss++; $display("FAIL eq_fail_a got=%0d exp=0", bus.fail_a); end
    vec++; if (bus.fail_b !== 4'd0)    begin miss++; $display("FAIL eq_fail_b got=%0d exp=0", bus.fail_b); end
    vec++; if (bus.fail_flags !== 3'b000) begin miss++; $display("FAIL eq_flags got=%b exp=000", bus.fail_flags); end
    vec++; if (bus.pass !== 1'b0)      begin miss++; $display("FAIL eq_pass got=%b exp=0", bus.pass); end
  endtask

  task automatic test_swap();
    int lat;
    fault_mode = 2;
    pulse_and_wait(lat);
    vec++; if (lat != SW_LAT)          begin miss++; $display("FAIL swap_latency got=%0d exp=%0d", lat, SW_LAT); end
    vec++; if (bus.err_cnt !== SW_ERR[8:0]) begin miss++; $display("FAIL swap_err got=%0d exp=%0d", bus.err_cnt, SW_ERR); end
    vec++; if (bus.fail_a !== 4'd0)    begin miss++; $display("FAIL swap_fail_a got=%0d exp=0", bus.fail_a); end
    vec++; if (bus.fail_b !== 4'd1)    begin miss++; $display("FAIL swap_fail_b got=%0d exp=1", bus.fail_b); end
    vec++; if (bus.fail_flags !== 3'b001) begin miss++; $display("FAIL swap_flags got=%b exp=001", bus.fail_flags); end
    fault_mode = 0;
    repeat (10) @(negedge clk);
    vec++; if (bus.err_cnt !== SW_ERR[8:0]) begin miss++; $display("FAIL swap_hold_err got=%0d exp=%0d", bus.err_cnt, SW_ERR); end
    vec++; if (bus.fail_b !== 4'd1)    begin miss++; $display("FAIL swap_hold_fail_b got=%0d exp=1", bus.fail_b); end
  endtask

  task automatic test_reset_mid_sweep();
    int lat;
    int dones;
    fault_mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++; if ({bus.busy, bus.done, bus.pass} !== 3'b000)
      begin miss++; $display("FAIL rstmid_ctrl got=%b exp=000", {bus.busy, bus.done, bus.pass}); end
    vec++; if ({bus.a, bus.b} !== 8'd0) begin miss++; $display("FAIL rstmid_ab got=%h exp=00", {bus.a, bus.b}); end
    vec++; if (bus.err_cnt !== 9'd0)    begin miss++; $display("FAIL rstmid_err got=%0d exp=0", bus.err_cnt); end
    vec++; if ({bus.fail_a, bus.fail_b, bus.fail_flags} !== 11'd0)
      begin miss++; $display("FAIL rstmid_fail got=%h exp=0", {bus.fail_a, bus.fail_b, bus.fail_flags}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    vec++; if (dones != 0) begin miss++; $display("FAIL rstmid_no_activity got=%0d exp=0", dones); end
    fault_mode = 0;
    pulse_and_wait(lat);
    vec++; if (lat != 513)        begin miss++; $display("FAIL rstmid_restart_lat got=%0d exp=513", lat); end
    vec++; if (bus.pass !== 1'b1) begin miss++; $display("FAIL rstmid_restart_pass got=%b exp=1", bus.pass); end
  endtask

  task automatic test_start_while_busy();
    int dones;
    int first;
    fault_mode = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    dones = 0;
    first = -1;
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      bus.start = (c == 50) || (c == 300);
      if (bus.done) begin
        dones++;
        if (first < 0) first = c;
      end
    end
    bus.start = 1'b0;
    vec++; if (dones != 1)   begin miss++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
    vec++; if (first != 513) begin miss++; $display("FAIL busy_done_cycle got=%0d exp=513", first); end
    vec++; if (bus.pass !== 1'b1) begin miss++; $display("FAIL busy_pass got=%b exp=1", bus.pass); end
  endtask

  initial begin
    vec        = 0;
    miss       = 0;
    fault_mode = 0;
    bus.start  = 1'b0;
    rst_n      = 1'b0;
    test_reset();
    test_good_sweep();
    test_eq_stuck();
    test_swap();
    test_reset_mid_sweep();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

`default_nettype wire
